// File: rtl/controlador_carga.sv
// Load-unit controller: one word-aligned read per request with a req/ack handshake,
// then byte/half lane trim and extension. Optional MISALIGN_TRAP_EN traps misaligned loads.
module controlador_carga #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_width,
    input  logic        ld_unsigned,
    output logic        ld_ready,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        err,
    output logic        err_misalign
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StErr} state_e;

    state_e      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  width_q, width_d;
    logic        uns_q, uns_d;
    logic        mis_q, mis_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [15:0] cnt_q, cnt_d;

    logic        misaligned;
    logic        expired;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] fmt_data;

    always_comb begin
        misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        unique case (ld_width)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ld_addr[0];
            default: misaligned = |ld_addr[1:0];
        endcase
`endif
    end

    // Expires on the cycle the counter would reach TIMEOUT_CYCLES.
    assign expired = ({1'b0, cnt_q} + 17'd1) >= 17'(TIMEOUT_CYCLES);

    always_comb begin
        byte_sel = 8'h00;
        unique case (lane_q)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        fmt_data = mem_rdata;
        unique case (width_q)
            2'b00:   fmt_data = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            2'b01:   fmt_data = {{16{half_sel[15] & ~uns_q}}, half_sel};
            default: fmt_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        width_d   = width_q;
        uns_d     = uns_q;
        mis_d     = mis_q;
        addr_d    = addr_q;
        wb_data_d = wb_data_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (ld_valid) begin
                    lane_d  = ld_addr[1:0];
                    width_d = ld_width;
                    uns_d   = ld_unsigned;
                    mis_d   = misaligned;
                    addr_d  = {ld_addr[31:2], 2'b00};
                    cnt_d   = 16'd0;
                    state_d = misaligned ? StErr : StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 16'd1;
                // An ack in the expiry cycle still completes the access.
                if (mem_ack) begin
                    wb_data_d = fmt_data;
                    state_d   = StResp;
                end else if (expired) begin
                    state_d = StErr;
                end
            end
            StResp:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            lane_q    <= 2'b00;
            width_q   <= 2'b00;
            uns_q     <= 1'b0;
            mis_q     <= 1'b0;
            addr_q    <= 32'h0;
            wb_data_q <= 32'h0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            width_q   <= width_d;
            uns_q     <= uns_d;
            mis_q     <= mis_d;
            addr_q    <= addr_d;
            wb_data_q <= wb_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ld_ready     = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign mem_req      = (state_q == StReq);
    assign mem_addr     = addr_q;
    assign wb_valid     = (state_q == StResp);
    assign wb_data      = wb_data_q;
    assign err          = (state_q == StErr);
    assign err_misalign = (state_q == StErr) & mis_q;

endmodule

// File: tb/tb_controlador_carga.sv
// Scoreboard bench for controlador_carga; a second instance with a short timeout
// covers the abort path.
module tb_controlador_carga;

    typedef struct {
        logic        is_err;
        logic        mis;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_unsigned, mem_ack;
    logic [31:0] ld_addr, mem_rdata;
    logic [1:0]  ld_width;
    logic        ld_ready, busy, mem_req, wb_valid, err, err_misalign;
    logic [31:0] mem_addr, wb_data;

    logic        t_ld_valid;
    logic [31:0] t_ld_addr;
    logic        t_ld_ready, t_busy, t_mem_req, t_wb_valid, t_err, t_err_mis;
    logic [31:0] t_mem_addr, t_wb_data;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    controlador_carga #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_width(ld_width), .ld_unsigned(ld_unsigned), .ld_ready(ld_ready),
        .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .err(err),
        .err_misalign(err_misalign)
    );

    controlador_carga #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst), .ld_valid(t_ld_valid), .ld_addr(t_ld_addr),
        .ld_width(2'b10), .ld_unsigned(1'b0), .ld_ready(t_ld_ready),
        .busy(t_busy), .mem_req(t_mem_req), .mem_addr(t_mem_addr), .mem_ack(1'b0),
        .mem_rdata(32'hDEAD_BEEF), .wb_valid(t_wb_valid), .wb_data(t_wb_data),
        .err(t_err), .err_misalign(t_err_mis)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every writeback or error pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (wb_valid || err)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", {30'd0, wb_valid, err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("sb_wb_valid", {31'd0, wb_valid}, {31'd0, ~e.is_err});
                check_eq("sb_err", {31'd0, err}, {31'd0, e.is_err});
                check_eq("sb_err_misalign", {31'd0, err_misalign}, {31'd0, e.mis});
                if (!e.is_err) check_eq("sb_wb_data", wb_data, e.data);
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!ld_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ld_ready) check_eq("ready_timeout", {31'd0, ld_ready}, 32'd1);
    endtask

    // Issue one load and acknowledge it on the ack_after-th REQ cycle.
    task automatic run_load(input logic [31:0] addr, input logic [1:0] w, input logic uns,
                            input logic [31:0] rdata, input int ack_after,
                            input logic [31:0] exp_data);
        exp_t e;
        @(negedge clk);
        wait_ready();
        ld_valid = 1'b1; ld_addr = addr; ld_width = w; ld_unsigned = uns;
        e.is_err = 1'b0; e.mis = 1'b0; e.data = exp_data;
        sb.push_back(e);
        @(posedge clk);
        #1 ld_valid = 1'b0;
        for (int c = 1; c <= ack_after; c++) begin
            @(negedge clk);
            check_eq("req_mem_req", {31'd0, mem_req}, 32'd1);
            check_eq("req_mem_addr", mem_addr, {addr[31:2], 2'b00});
            check_eq("req_ld_ready", {31'd0, ld_ready}, 32'd0);
            check_eq("req_busy", {31'd0, busy}, 32'd1);
            if (c == ack_after) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end
        end
        @(posedge clk);
        #1 mem_ack = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        check_eq("resp_wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("resp_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check_eq("after_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("after_ld_ready", {31'd0, ld_ready}, 32'd1);
        check_eq("wb_data_hold", wb_data, exp_data);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; ld_valid = 1'b0; ld_addr = 32'h0; ld_width = 2'b00; ld_unsigned = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'h0; t_ld_valid = 1'b0; t_ld_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_wb", {30'd0, wb_valid, err}, 32'd0);
        check_eq("rst_wb_data", wb_data, 32'h0);
        check_eq("rst_err_mis", {31'd0, err_misalign}, 32'd0);

        run_load(32'h0000_1003, 2'b00, 1'b0, 32'h80FF_1234, 1, 32'hFFFF_FF80);
        run_load(32'h0000_2002, 2'b01, 1'b1, 32'hBEEF_0001, 1, 32'h0000_BEEF);
        run_load(32'h0000_2002, 2'b01, 1'b0, 32'hBEEF_0001, 2, 32'hFFFF_BEEF);
        run_load(32'h0000_3000, 2'b10, 1'b0, 32'h1234_5678, 5, 32'h1234_5678);
        run_load(32'h0000_1001, 2'b00, 1'b1, 32'h80FF_1234, 1, 32'h0000_0012);
        run_load(32'h0000_1000, 2'b00, 1'b0, 32'h80FF_1234, 3, 32'h0000_0034);
        run_load(32'h0000_5000, 2'b11, 1'b1, 32'h8765_4321, 1, 32'h8765_4321);
        // Ack on the very cycle the 8-cycle timeout expires: ack must win.
        run_load(32'h0000_6000, 2'b10, 1'b0, 32'hCAFE_F00D, 8, 32'hCAFE_F00D);

        // Timeout on the short-timeout instance.
        @(negedge clk);
        t_ld_valid = 1'b1; t_ld_addr = 32'h0000_7000;
        @(posedge clk);
        #1 t_ld_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("to_mem_req", {31'd0, t_mem_req}, 32'd1);
            check_eq("to_no_err", {31'd0, t_err}, 32'd0);
        end
        @(negedge clk);
        check_eq("to_mem_req_drop", {31'd0, t_mem_req}, 32'd0);
        check_eq("to_err", {31'd0, t_err}, 32'd1);
        check_eq("to_err_mis", {31'd0, t_err_mis}, 32'd0);
        check_eq("to_wb_valid", {31'd0, t_wb_valid}, 32'd0);
        @(negedge clk);
        check_eq("to_err_pulse", {31'd0, t_err}, 32'd0);
        check_eq("to_ld_ready", {31'd0, t_ld_ready}, 32'd1);
        check_eq("to_wb_data", t_wb_data, 32'h0);

        // Reset while in REQ: access aborted silently.
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'h0000_8000; ld_width = 2'b10;
        @(posedge clk);
        #1 ld_valid = 1'b0;
        @(negedge clk);
        check_eq("rreq_mem_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rreq_mem_req_drop", {31'd0, mem_req}, 32'd0);
        check_eq("rreq_ld_ready", {31'd0, ld_ready}, 32'd1);
        check_eq("rreq_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        // Back-to-back with ld_valid held high.
        ld_valid = 1'b1; ld_addr = 32'h0000_9000; ld_width = 2'b10; ld_unsigned = 1'b0;
        e.is_err = 1'b0; e.mis = 1'b0; e.data = 32'hA5A5_5A5A;
        sb.push_back(e);
        sb.push_back(e);
        @(negedge clk);
        check_eq("b2b_req1", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        check_eq("b2b_resp_not_ready", {31'd0, ld_ready}, 32'd0);
        @(negedge clk);
        check_eq("b2b_idle_ready", {31'd0, ld_ready}, 32'd1);
        check_eq("b2b_idle_no_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1 ld_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b_req2", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Misaligned half.
`ifdef MISALIGN_TRAP_EN
        ld_valid = 1'b1; ld_addr = 32'h0000_4001; ld_width = 2'b01; ld_unsigned = 1'b1;
        e.is_err = 1'b1; e.mis = 1'b1; e.data = 32'h0;
        sb.push_back(e);
        @(posedge clk);
        #1 ld_valid = 1'b0;
        @(negedge clk);
        check_eq("mis_no_req", {31'd0, mem_req}, 32'd0);
        check_eq("mis_err", {31'd0, err}, 32'd1);
        check_eq("mis_err_misalign", {31'd0, err_misalign}, 32'd1);
        @(negedge clk);
        check_eq("mis_err_pulse", {31'd0, err}, 32'd0);
        check_eq("mis_ld_ready", {31'd0, ld_ready}, 32'd1);
`else
        run_load(32'h0000_4001, 2'b01, 1'b1, 32'h1111_2222, 1, 32'h0000_2222);
`endif

        repeat (3) @(negedge clk);
        check_eq("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/controlador_carga.md
Name: controlador_carga

Overview:
- Load-unit controller between the pipeline's memory stage and the data-memory port.
- Accepts one load request at a time and issues a word-aligned read with a req/ack handshake.
- Selects the addressed byte or halfword lane, applies sign or zero extension, and returns a one-cycle writeback pulse.
- Sequences and configures the lane-trim/extension datapath, and guards against a memory that never answers.

Parameters:
- TIMEOUT_CYCLES, 255, number of REQ-state cycles without mem_ack before the access is aborted (range 1..65535).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- ld_valid  in  1  load request from the memory stage
- ld_addr  in  32  byte address of the load
- ld_width  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- ld_unsigned  in  1  1 = zero-extend (LBU/LHU), 0 = sign-extend
- ld_ready  out  1  controller can accept a request this cycle
- busy  out  1  stall to the pipeline; high whenever state != IDLE
- mem_req  out  1  read request to data memory
- mem_addr  out  32  word-aligned address, {ld_addr[31:2],2'b00}
- mem_ack  in  1  memory has valid mem_rdata this cycle
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse, wb_data valid
- wb_data  out  32  trimmed and extended load result
- err  out  1  one-cycle pulse, access aborted (timeout or misalign)
- err_misalign  out  1  qualifies err; 1 = misaligned cause

Behaviour:
- States: IDLE, REQ, RESP, ERR.
- Reset (synchronous, rst high at a clk edge): state=IDLE; ld_ready=1; busy=0; mem_req=0; mem_addr=0; wb_valid=0; wb_data=0; err=0; err_misalign=0; timeout counter=0.
- IDLE:
  - ld_ready=1.
  - On ld_valid: latch addr[1:0], width and unsigned; set mem_addr; go to REQ.
  - mem_ack is ignored in IDLE.
- REQ:
  - mem_req=1 and mem_addr is held stable.
  - Counter increments each cycle.
  - mem_ack=1 sampled: format mem_rdata into wb_data; go to RESP.
  - Counter reaches TIMEOUT_CYCLES with no ack: go to ERR.
  - If ack arrives in the same cycle the counter expires, the ack wins.
- RESP: wb_valid=1 for exactly one cycle; mem_req=0; go to IDLE.
- ERR: err=1 for exactly one cycle; wb_valid=0; wb_data is unchanged; go to IDLE.
- Latency: accept at cycle N; mem_req from N+1; ack at cycle M gives wb_valid at M+1. Minimum is 2 cycles request-to-writeback.
- ld_ready=0 in every state except IDLE. ld_valid while not ready is not captured; the requester holds the request.
- Byte formatting: lane = addr[1:0]; result = rdata[8*lane+7 : 8*lane], extended from bit 7 unless unsigned.
- Half formatting: lane = addr[1]; result = rdata[16*lane+15 : 16*lane], extended from bit 15 unless unsigned.
- Word formatting: rdata unchanged; ld_unsigned ignored.
- wb_data holds its last value between pulses.
- rst asserted in REQ: mem_req drops at that edge, and no wb_valid or err is produced for the aborted access.
- Counter clears on every entry to REQ.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a request with a misaligned address goes IDLE -> ERR without asserting mem_req. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. In ERR: err=1 and err_misalign=1 for one cycle.
- Not defined: misaligned address bits are ignored (half uses addr[1] only; word uses addr[31:2]). The access proceeds normally, and err_misalign is tied 0.

Test Plan:
- Byte, sign-extend: ld_addr=0x1003, width=00, unsigned=0, rdata=0x80FF_1234, ack 1 cycle after mem_req -> mem_addr=0x1000; wb_valid 2 cycles after accept; wb_data=0xFFFF_FF80.
- Half, zero-extend: addr=0x2002, width=01, unsigned=1, rdata=0xBEEF_0001 -> wb_data=0x0000_BEEF. Repeat with unsigned=0 -> 0xFFFF_BEEF.
- Word with delayed ack: addr=0x3000, width=10, ack after 5 REQ cycles, rdata=0x1234_5678 -> mem_req high exactly 5 cycles; ld_ready=0 and busy=1 throughout; wb_data=0x1234_5678.
- Timeout: TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req high 4 cycles; then err=1, err_misalign=0 for 1 cycle; wb_valid stays 0; ld_ready=1 the next cycle.
- Reset mid-access, then back-to-back: rst pulsed during REQ -> mem_req=0 after the edge and no wb_valid. Next, ld_valid held high across two loads -> second request accepted only in the cycle after the first load's wb_valid.
- Misaligned half (addr=0x4001, width=01), rdata=0x1111_2222, unsigned=1:
  - With MISALIGN_TRAP_EN: mem_req never asserts; err=1 and err_misalign=1 one cycle after accept.
  - Without MISALIGN_TRAP_EN: wb_data=0x0000_2222.
